// File: rtl/nested_addr_gen_pkg.sv
// Shared types and helpers for the nested loop address generator.
// Contents:
//   state_t     - run-control FSM states
//   bound_lsb   - LSB position of level i inside the flattened bound bus
//   stride_lsb  - LSB position of level i inside the flattened stride bus
package nested_addr_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned bound_lsb(input int unsigned lvl,
                                              input int unsigned level_width);
        return lvl * level_width;
    endfunction

    function automatic int unsigned stride_lsb(input int unsigned lvl,
                                               input int unsigned addr_width);
        return lvl * addr_width;
    endfunction

endpackage

// File: rtl/nested_addr_gen_if.sv
// Control/config and address-stream bundle for nested_addr_gen.
// master: the side that starts runs and consumes addresses.
// slave : the address generator itself.
//   start, abort            run control (master -> slave)
//   cfg_base/bound/stride   run configuration, latched on start
//   busy, done              run status (slave -> master)
//   addr_valid/addr_ready   address stream handshake
//   addr, addr_last         address beat and final-beat flag
//   level_wrap              per-level wrap flags of the current beat
interface nested_addr_gen_if #(
    parameter int NUM_LEVELS  = 3,
    parameter int LEVEL_WIDTH = 8,
    parameter int ADDR_WIDTH  = 16
);
    logic                              start;
    logic                              abort;
    logic [ADDR_WIDTH-1:0]             cfg_base;
    logic [NUM_LEVELS*LEVEL_WIDTH-1:0] cfg_bound;
    logic [NUM_LEVELS*ADDR_WIDTH-1:0]  cfg_stride;
    logic                              busy;
    logic                              done;
    logic                              addr_valid;
    logic                              addr_ready;
    logic [ADDR_WIDTH-1:0]             addr;
    logic                              addr_last;
    logic [NUM_LEVELS-1:0]             level_wrap;

    modport master (
        output start, abort, cfg_base, cfg_bound, cfg_stride, addr_ready,
        input  busy, done, addr_valid, addr, addr_last, level_wrap
    );

    modport slave (
        input  start, abort, cfg_base, cfg_bound, cfg_stride, addr_ready,
        output busy, done, addr_valid, addr, addr_last, level_wrap
    );
endinterface

// File: rtl/nested_addr_gen_lvl.sv
// One loop level: index, running offset and the latched bound/stride.
// Ports:
//   CLK, rst   clock, async active-high reset
//   load       latch cfg_bound/cfg_stride and clear idx/offset
//   clear      clear idx/offset (run cancelled)
//   adv        a beat was transferred this cycle
//   carry_in   all inner levels are at their bound (1 for level 0 in RUN)
//   carry_out  this level wraps on the current beat; feeds the next level
//   wrap       same as carry_out, exported as the level_wrap flag
//   offset     idx * stride, maintained incrementally
module addr_level_cnt #(
    parameter int LEVEL_WIDTH = 8,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   clear,
    input  logic                   adv,
    input  logic [LEVEL_WIDTH-1:0] cfg_bound,
    input  logic [ADDR_WIDTH-1:0]  cfg_stride,
    input  logic                   carry_in,
    output logic                   carry_out,
    output logic                   wrap,
    output logic [ADDR_WIDTH-1:0]  offset
);
    logic [LEVEL_WIDTH-1:0] idx_q;
    logic [LEVEL_WIDTH-1:0] bound_q;
    logic [ADDR_WIDTH-1:0]  stride_q;
    logic [ADDR_WIDTH-1:0]  offset_q;
    logic                   at_bound;

    assign at_bound  = (idx_q == bound_q - LEVEL_WIDTH'(1));
    assign carry_out = carry_in && at_bound;
    assign wrap      = carry_out;
    assign offset    = offset_q;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            bound_q  <= '0;
            stride_q <= '0;
            offset_q <= '0;
        end else if (load) begin
            // a zero trip count runs the level once
            bound_q  <= (cfg_bound == '0) ? LEVEL_WIDTH'(1) : cfg_bound;
            stride_q <= cfg_stride;
            idx_q    <= '0;
            offset_q <= '0;
        end else if (clear) begin
            idx_q    <= '0;
            offset_q <= '0;
        end else if (adv && carry_in) begin
            if (at_bound) begin
                idx_q    <= '0;
                offset_q <= '0;
            end else begin
                idx_q    <= idx_q + LEVEL_WIDTH'(1);
                offset_q <= offset_q + stride_q;
            end
        end
    end
endmodule

// File: rtl/nested_addr_gen.sv
// Runtime-configurable NUM_LEVELS-deep nested loop address generator.
// Level 0 is innermost. addr = base + sum of per-level offsets (mod 2^ADDR_WIDTH).
// Ports:
//   CLK, rst   clock, async active-high reset
//   bus        nested_addr_gen_if slave modport: start/abort control,
//              cfg_* (latched on start), busy/done status and the
//              addr_valid/addr_ready address stream with addr_last
//              and level_wrap flags
module nested_addr_gen
    import nested_addr_gen_pkg::*;
#(
    parameter int NUM_LEVELS  = 3,
    parameter int LEVEL_WIDTH = 8,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic              CLK,
    input  logic              rst,
    nested_addr_gen_if.slave  bus
);
    state_t                  state_q;
    state_t                  state_nx;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [NUM_LEVELS:0]     carry;
    logic [NUM_LEVELS-1:0]   wraps;
    logic [ADDR_WIDTH-1:0]   offs [NUM_LEVELS];
    logic [ADDR_WIDTH-1:0]   addr_sum;
    logic                    load;
    logic                    clear;
    logic                    xfer;
    logic                    running;

    assign running = (state_q == RUN);
    assign load    = (state_q == IDLE) && bus.start;
    assign clear   = running && bus.abort;
    assign xfer    = running && bus.addr_ready;

    // carry chain is only live in RUN so wrap/last read 0 elsewhere
    assign carry[0] = running;

    for (genvar i = 0; i < NUM_LEVELS; i++) begin : g_lvl
        addr_level_cnt #(
            .LEVEL_WIDTH(LEVEL_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_lvl (
            .CLK       (CLK),
            .rst       (rst),
            .load      (load),
            .clear     (clear),
            .adv       (xfer),
            .cfg_bound (bus.cfg_bound[bound_lsb(i, LEVEL_WIDTH) +: LEVEL_WIDTH]),
            .cfg_stride(bus.cfg_stride[stride_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH]),
            .carry_in  (carry[i]),
            .carry_out (carry[i+1]),
            .wrap      (wraps[i]),
            .offset    (offs[i])
        );
    end

    always_comb begin
        addr_sum = base_q;
        for (int unsigned i = 0; i < NUM_LEVELS; i++) begin
            addr_sum = addr_sum + offs[i];
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_nx;
            if (load) begin
                base_q <= bus.cfg_base;
            end
        end
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE: if (bus.start) state_nx = RUN;
            RUN: begin
                // abort takes priority over a final-beat transfer
                if (bus.abort)                  state_nx = IDLE;
                else if (xfer && carry[NUM_LEVELS]) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        bus.addr_valid = 1'b0;
        case (state_q)
            RUN: begin
                bus.busy       = 1'b1;
                bus.addr_valid = 1'b1;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.addr       = addr_sum;
    assign bus.addr_last  = carry[NUM_LEVELS];
    assign bus.level_wrap = wraps;
endmodule

// File: doc/nested_addr_gen.md
Name: nested_addr_gen

Overview:
Runtime-configurable N-level nested loop address generator. It replaces fixed two-level compile-time counters in the datapath address paths.
- Each level has its own trip count (bound) and stride. Output address = base + sum of per-level offsets.
- A start/busy/done handshake controls each run. A valid/ready stream carries addresses to the memory or PE side.
- Level 0 is the innermost level.

Parameters:
- NUM_LEVELS, 3, number of nested loop levels (>=1).
- LEVEL_WIDTH, 8, width of each level's index and bound.
- ADDR_WIDTH, 16, width of address, base and strides.

Ports:
- CLK  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  synchronous run cancel.
- cfg_base  in  ADDR_WIDTH  base address, latched on start.
- cfg_bound  in  NUM_LEVELS*LEVEL_WIDTH  per-level trip counts, level i at [i*LEVEL_WIDTH +: LEVEL_WIDTH]; latched on start.
- cfg_stride  in  NUM_LEVELS*ADDR_WIDTH  per-level strides, level i at [i*ADDR_WIDTH +: ADDR_WIDTH]; latched on start.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the final beat is transferred.
- addr_valid  out  1  address beat valid.
- addr_ready  in  1  downstream accepts the beat.
- addr  out  ADDR_WIDTH  current address.
- addr_last  out  1  current beat is the final beat of the run.
- level_wrap  out  NUM_LEVELS  bit i high when level i wraps on the current beat.

Behaviour:
- Reset: all of the following are 0: state, indices, offsets, latched config, busy, done, addr_valid, addr_last, level_wrap. addr reads 0.
- State IDLE:
  - If start=1, latch cfg_* and clear every idx_i and offset_i.
  - A latched bound of 0 is treated as 1.
  - Go to RUN. start is ignored in every other state.
- State RUN:
  - busy=1 and addr_valid=1.
  - First beat appears the cycle after start (latency 1) with addr = base.
- Transfer rule: a transfer occurs when addr_valid && addr_ready.
  - Without a transfer, addr, addr_last and level_wrap hold stable. No beat is dropped or duplicated.
- Per-level advance on a transfer:
  - carry_0 = 1. carry_(i+1) = carry_i && (idx_i == bound_i-1).
  - If carry_i and not at bound: idx_i += 1 and offset_i += stride_i.
  - If carry_i and at bound: idx_i = 0 and offset_i = 0.
  - Offsets are updated incrementally. No multipliers.
- Arithmetic:
  - addr = base + sum(offset_i), modulo 2^ADDR_WIDTH. Overflow wraps silently.
  - addr is combinational from registered state.
- Wrap and last flags:
  - level_wrap[i] = carry_i && (idx_i == bound_i-1), evaluated on the current beat.
  - addr_last = level_wrap[NUM_LEVELS-1], which implies all levels are at their bound.
- Beat count: total beats per run = product of effective bounds.
- Run completion:
  - A transfer with addr_last=1 moves the block to DONE.
  - In DONE: done=1, addr_valid=0, busy=0 for exactly one cycle, then IDLE.
  - start is not accepted during DONE. The earliest restart is the cycle after done.
- Abort:
  - abort=1 in RUN moves the block to IDLE next cycle. done does not pulse; indices clear.
  - Abort wins over a simultaneous transfer. The beat counts as consumed downstream, but no further beats follow.
  - abort in IDLE or DONE has no effect.
- Reset mid-run: asynchronous return to the reset values. No done pulse.
- Config inputs may change freely while busy. Only the values latched at start are used.

Decomposition:
- Package nested_addr_gen_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - slice-index helper functions for the flattened cfg buses.
- Sub-module addr_level_cnt, instantiated NUM_LEVELS times via generate. It holds one level's idx, offset, bound and stride registers, takes carry_in, and produces carry_out and wrap.
- The top level contains the FSM, the offset adder tree and the handshake.

Test Plan:
1. Basic run: NUM_LEVELS=2, bounds {3,2}, strides {1,10}, base 100, ready=1.
   - Expect addr 100,101,102,110,111,112.
   - Expect level_wrap[0] on beats 3 and 6, addr_last on beat 6 only.
   - Expect done one cycle after beat 6, then busy=0.
2. Backpressure: same config as test 1, ready=0 for 3 cycles while addr=101.
   - Expect 101 held with valid=1 throughout.
   - Resumes at 102. Total of exactly 6 transfers.
3. Degenerate bounds: NUM_LEVELS=3, bounds {1,0,1}, base 0x40.
   - Expect a single beat at 0x40 with addr_last=1 and level_wrap=3'b111, then done.
4. Address overflow: base 0xFFFE, bound0=4, stride0=1, ADDR_WIDTH=16.
   - Expect FFFE, FFFF, 0000, 0001, then done.
5. Start and abort control: start pulsed in RUN is ignored and the sequence continues unchanged.
   - Then assert abort on the same cycle as the beat-2 transfer.
   - Expect IDLE next cycle, valid=0, no done.
   - A new start then begins again at base.
6. Reset mid-run: assert rst asynchronously (between clock edges) during beat 4.
   - Expect all outputs 0 immediately; no done.
   - After release, a start replays the full sequence from base.
